// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the decoder control-word pipeline.
//   CTRL_W            width of the packed control word
//   *_MSB/*_LSB/*_BIT bit positions of each field inside the word
//   ctrl_word_t       packed struct matching the word layout, MSB first
//   NOP_SQUASH_MASK   AND-mask that turns any word into a side-effect-free NOP
//   squashCtrl()      applies the mask to a control word
package ctrl_pkg;

    localparam int CTRL_W = 42;

    localparam int AF_MSB             = 41;
    localparam int AF_LSB             = 38;
    localparam int I_BIT              = 37;
    localparam int ALU_MUX_SEL_BIT    = 36;
    localparam int SHIFT_TYPE_MSB     = 35;
    localparam int SHIFT_TYPE_LSB     = 33;
    localparam int CAD_MSB            = 32;
    localparam int CAD_LSB            = 28;
    localparam int GP_WE_BIT          = 27;
    localparam int GP_MUX_SEL_MSB     = 26;
    localparam int GP_MUX_SEL_LSB     = 24;
    localparam int BF_MSB             = 23;
    localparam int BF_LSB             = 20;
    localparam int PC_MUX_SELECT_MSB  = 19;
    localparam int PC_MUX_SELECT_LSB  = 18;
    localparam int SPR_MUX_SEL_BIT    = 17;
    localparam int MEM_WREN_BIT       = 16;
    localparam int MEM_RREN_BIT       = 15;
    localparam int RS_MSB             = 14;
    localparam int RS_LSB             = 10;
    localparam int RT_MSB             = 9;
    localparam int RT_LSB             = 5;
    localparam int RD_MSB             = 4;
    localparam int RD_LSB             = 0;

    typedef struct packed {
        logic [3:0] af;
        logic       i;
        logic       alu_mux_sel;
        logic [2:0] shift_type;
        logic [4:0] cad;
        logic       gp_we;
        logic [2:0] gp_mux_sel;
        logic [3:0] bf;
        logic [1:0] pc_mux_select;
        logic       spr_mux_sel;
        logic       mem_wren;
        logic       mem_rren;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ctrl_word_t;

    // A squashed word may still flow to execute, but it must not write the
    // register file, touch memory or redirect the PC.
    localparam logic [CTRL_W-1:0] NOP_SQUASH_MASK =
        ~((CTRL_W'(1) << GP_WE_BIT)         |
          (CTRL_W'(3) << PC_MUX_SELECT_LSB) |
          (CTRL_W'(1) << MEM_WREN_BIT)      |
          (CTRL_W'(1) << MEM_RREN_BIT));

    function automatic ctrl_word_t squashCtrl(input ctrl_word_t word);
        return ctrl_word_t'(word & NOP_SQUASH_MASK);
    endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage
// One slot of the control-word pipeline: a valid bit plus control word and
// sideband registers.
//   clk, rst        clock and asynchronous active-high reset
//   up_valid_i      upstream slot (or pipeline input) holds a word
//   up_ctrl_i       upstream control word
//   up_side_i       upstream sideband payload
//   down_accept_i   downstream slot (or consumer) accepts this cycle
//   flush_i         kill or squash the in-flight contents
//   valid_o         this slot holds a word
//   ctrl_o, side_o  stored control word and sideband
module ctrl_pipe_stage
    import ctrl_pkg::*;
#(
    parameter int SIDE_W      = 32,
    parameter int SQUASH_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid_i,
    input  ctrl_word_t        up_ctrl_i,
    input  logic [SIDE_W-1:0] up_side_i,
    input  logic              down_accept_i,
    input  logic              flush_i,
    output logic              valid_o,
    output ctrl_word_t        ctrl_o,
    output logic [SIDE_W-1:0] side_o
);

    logic              valid_q, valid_d;
    ctrl_word_t        ctrl_q, ctrl_d;
    logic [SIDE_W-1:0] side_q, side_d;
    logic              accept;

    // An empty slot always loads; a full one loads only when its current
    // word moves on, which is what lets bubbles collapse under a stall.
    assign accept = !valid_q || down_accept_i;

    // Next-state: load from upstream when accepting, then apply the flush.
    // Mode 0 drops every entry; mode 1 keeps entries but neuters them,
    // including a word entering in the flush cycle.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        side_d  = side_q;
        if (accept) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                ctrl_d = up_ctrl_i;
                side_d = up_side_i;
            end
        end
        if (flush_i) begin
            if (SQUASH_MODE == 0) begin
                valid_d = 1'b0;
            end else begin
                ctrl_d = squashCtrl(ctrl_d);
            end
        end
    end

    // Slot registers; reset clears data too so outputs read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            side_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            side_q  <= side_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign side_o  = side_q;

endmodule

// File: rtl/ctrl_word_pipe.sv
// ctrl_word_pipe
// DEPTH-slot stall-aware pipeline carrying the decoder control word and a
// sideband payload, with the last slot unpacked into named fields.
//   clk, rst              clock and asynchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ctrl/in_side payload
//   flush                 kill (SQUASH_MODE=0) or NOP-squash (=1) in-flight words
//   out_valid/out_ready   downstream handshake; out_side sideband
//   af .. rd              unpacked fields of the final slot
//   occupancy             number of valid slots
module ctrl_word_pipe
    import ctrl_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int SIDE_W      = 32,
    parameter int SQUASH_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [SIDE_W-1:0]          in_side,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIDE_W-1:0]          out_side,
    output logic [3:0]                 af,
    output logic                       i,
    output logic                       alu_mux_sel,
    output logic [2:0]                 shift_type,
    output logic [4:0]                 cad,
    output logic                       gp_we,
    output logic [2:0]                 gp_mux_sel,
    output logic [3:0]                 bf,
    output logic [1:0]                 pc_mux_select,
    output logic                       spr_mux_sel,
    output logic                       mem_wren,
    output logic                       mem_rren,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  stageValid;
    logic [DEPTH-1:0]  downAccept;
    logic              headAccept;
    ctrl_word_t        stageCtrl [DEPTH];
    logic [SIDE_W-1:0] stageSide [DEPTH];
    ctrl_word_t        inWord;
    ctrl_word_t        outWord;
    logic [OCC_W-1:0]  occCount;

    assign inWord = ctrl_word_t'(in_ctrl);

    // Accept chain from the consumer back to the head. Built in one process
    // so the ripple stays a plain expression rather than a signal loop.
    // in_valid is deliberately not part of it.
    always_comb begin
        logic ready;
        downAccept = '0;
        ready      = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            downAccept[k] = ready;
            ready         = !stageValid[k] || ready;
        end
        headAccept = ready;
    end

    assign in_ready = headAccept;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              upValid;
        ctrl_word_t        upCtrl;
        logic [SIDE_W-1:0] upSide;

        if (k == 0) begin : g_head
            assign upValid = in_valid;
            assign upCtrl  = inWord;
            assign upSide  = in_side;
        end else begin : g_body
            assign upValid = stageValid[k-1];
            assign upCtrl  = stageCtrl[k-1];
            assign upSide  = stageSide[k-1];
        end

        ctrl_pipe_stage #(
            .SIDE_W      (SIDE_W),
            .SQUASH_MODE (SQUASH_MODE)
        ) u_stage (
            .clk           (clk),
            .rst           (rst),
            .up_valid_i    (upValid),
            .up_ctrl_i     (upCtrl),
            .up_side_i     (upSide),
            .down_accept_i (downAccept[k]),
            .flush_i       (flush),
            .valid_o       (stageValid[k]),
            .ctrl_o        (stageCtrl[k]),
            .side_o        (stageSide[k])
        );
    end

    // Popcount of slot valids.
    always_comb begin
        occCount = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occCount = occCount + OCC_W'(stageValid[k]);
        end
    end

    assign occupancy = occCount;

    assign outWord   = stageCtrl[DEPTH-1];
    assign out_valid = stageValid[DEPTH-1];
    assign out_side  = stageSide[DEPTH-1];

    assign af            = outWord.af;
    assign i             = outWord.i;
    assign alu_mux_sel   = outWord.alu_mux_sel;
    assign shift_type    = outWord.shift_type;
    assign cad           = outWord.cad;
    assign gp_we         = outWord.gp_we;
    assign gp_mux_sel    = outWord.gp_mux_sel;
    assign bf            = outWord.bf;
    assign pc_mux_select = outWord.pc_mux_select;
    assign spr_mux_sel   = outWord.spr_mux_sel;
    assign mem_wren      = outWord.mem_wren;
    assign mem_rren      = outWord.mem_rren;
    assign rs            = outWord.rs;
    assign rt            = outWord.rt;
    assign rd            = outWord.rd;

endmodule

// File: tb/tb_ctrl_word_pipe.sv
// tb_ctrl_word_pipe
// Directed bench for ctrl_word_pipe (DEPTH=2). Two instances share stimulus:
// dut0 drops on flush, dut1 squashes to NOP on flush.
module tb_ctrl_word_pipe;

    localparam int SIDE_W = 32;

    logic              clk;
    logic              rst;
    logic              inValid;
    logic [41:0]       inCtrl;
    logic [SIDE_W-1:0] inSide;
    logic              flush;
    logic              outReady;

    logic              inReady0, outValid0;
    logic [SIDE_W-1:0] outSide0;
    logic [3:0]        af0, bf0;
    logic              i0, alu0, gpWe0, spr0, wren0, rren0;
    logic [2:0]        shift0, gpMux0;
    logic [4:0]        cad0, rs0, rt0, rd0;
    logic [1:0]        pc0, occ0;

    logic              inReady1, outValid1;
    logic [SIDE_W-1:0] outSide1;
    logic [3:0]        af1, bf1;
    logic              i1, alu1, gpWe1, spr1, wren1, rren1;
    logic [2:0]        shift1, gpMux1;
    logic [4:0]        cad1, rs1, rt1, rd1;
    logic [1:0]        pc1, occ1;

    logic [41:0]       obsWord0, obsWord1;

    int checkCount = 0;
    int errorCount = 0;

    assign obsWord0 = {af0, i0, alu0, shift0, cad0, gpWe0, gpMux0, bf0, pc0,
                       spr0, wren0, rren0, rs0, rt0, rd0};
    assign obsWord1 = {af1, i1, alu1, shift1, cad1, gpWe1, gpMux1, bf1, pc1,
                       spr1, wren1, rren1, rs1, rt1, rd1};

    ctrl_word_pipe #(.DEPTH(2), .SIDE_W(SIDE_W), .SQUASH_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
        .in_ctrl(inCtrl), .in_side(inSide), .flush(flush),
        .out_valid(outValid0), .out_ready(outReady), .out_side(outSide0),
        .af(af0), .i(i0), .alu_mux_sel(alu0), .shift_type(shift0), .cad(cad0),
        .gp_we(gpWe0), .gp_mux_sel(gpMux0), .bf(bf0), .pc_mux_select(pc0),
        .spr_mux_sel(spr0), .mem_wren(wren0), .mem_rren(rren0),
        .rs(rs0), .rt(rt0), .rd(rd0), .occupancy(occ0)
    );

    ctrl_word_pipe #(.DEPTH(2), .SIDE_W(SIDE_W), .SQUASH_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1),
        .in_ctrl(inCtrl), .in_side(inSide), .flush(flush),
        .out_valid(outValid1), .out_ready(outReady), .out_side(outSide1),
        .af(af1), .i(i1), .alu_mux_sel(alu1), .shift_type(shift1), .cad(cad1),
        .gp_we(gpWe1), .gp_mux_sel(gpMux1), .bf(bf1), .pc_mux_select(pc1),
        .spr_mux_sel(spr1), .mem_wren(wren1), .mem_rren(rren1),
        .rs(rs1), .rt(rt1), .rd(rd1), .occupancy(occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds a control word from fields in the documented MSB-first order.
    function automatic logic [41:0] mkWord(
        input logic [3:0] a, input logic ib, input logic alu,
        input logic [2:0] sh, input logic [4:0] cd, input logic we,
        input logic [2:0] gm, input logic [3:0] b, input logic [1:0] pc,
        input logic sp, input logic wr, input logic rr,
        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {a, ib, alu, sh, cd, we, gm, b, pc, sp, wr, rr, s, t, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [41:0] c,
                                 input logic [SIDE_W-1:0] s, input logic ordy,
                                 input logic fl);
        inValid  = v;
        inCtrl   = c;
        inSide   = s;
        outReady = ordy;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [41:0] W1 = 42'h2AAAAAAAAAA;
    localparam logic [41:0] W2 = 42'h15555555555;
    localparam logic [41:0] WA = 42'h0ABCDEF0123;
    localparam logic [41:0] WB = 42'h13579BDF024;
    localparam logic [41:0] WC = 42'h2468ACE1357;

    logic [41:0] ws, wsSquashed;

    initial begin
        ws         = mkWord(4'hF, 1'b1, 1'b0, 3'b101, 5'h13, 1'b1, 3'b010, 4'h9,
                            2'b11, 1'b1, 1'b1, 1'b1, 5'h11, 5'h0C, 5'h1B);
        wsSquashed = mkWord(4'hF, 1'b1, 1'b0, 3'b101, 5'h13, 1'b0, 3'b010, 4'h9,
                            2'b00, 1'b1, 1'b0, 1'b0, 5'h11, 5'h0C, 5'h1B);

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #10;
        checkOutput("reset out_valid", outValid0, 0);
        checkOutput("reset occupancy", occ0, 0);
        checkOutput("reset in_ready", inReady0, 1);
        checkOutput("reset word", obsWord0, 0);
        checkOutput("reset side", outSide0, 0);
        rst = 1'b0;
        tick();

        // Zero-stall stream, latency of two cycles
        applyStimulus(1'b1, W1, 32'h11, 1'b1, 1'b0);
        checkOutput("stream in_ready", inReady0, 1);
        tick();
        applyStimulus(1'b1, W2, 32'h22, 1'b1, 1'b0);
        checkOutput("stream occ after 1", occ0, 1);
        checkOutput("stream not yet out", outValid0, 0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("stream W1 valid", outValid0, 1);
        checkOutput("stream W1 word", obsWord0, W1);
        checkOutput("stream W1 rd", rd0, 5'h0A);
        checkOutput("stream W1 side", outSide0, 32'h11);
        checkOutput("stream occ peak", occ0, 2);
        tick();
        checkOutput("stream W2 word", obsWord0, W2);
        checkOutput("stream W2 rd", rd0, 5'h15);
        checkOutput("stream W2 side", outSide0, 32'h22);
        checkOutput("stream occ drain", occ0, 1);
        tick();
        checkOutput("stream empty", outValid0, 0);
        checkOutput("stream occ empty", occ0, 0);

        // Output stall with three words offered
        applyStimulus(1'b1, WA, 32'hA, 1'b0, 1'b0);
        checkOutput("stall accept A", inReady0, 1);
        tick();
        applyStimulus(1'b1, WB, 32'hB, 1'b0, 1'b0);
        checkOutput("stall accept B", inReady0, 1);
        tick();
        applyStimulus(1'b1, WC, 32'hC, 1'b0, 1'b0);
        checkOutput("stall full in_ready", inReady0, 0);
        checkOutput("stall full occ", occ0, 2);
        checkOutput("stall head word", obsWord0, WA);
        tick();
        checkOutput("stall hold word", obsWord0, WA);
        checkOutput("stall hold side", outSide0, 32'hA);
        checkOutput("stall hold in_ready", inReady0, 0);
        applyStimulus(1'b1, WC, 32'hC, 1'b1, 1'b0);
        checkOutput("full ready in_ready", inReady0, 1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("drain B word", obsWord0, WB);
        checkOutput("drain occ unchanged", occ0, 2);
        tick();
        checkOutput("drain C word", obsWord0, WC);
        checkOutput("drain C side", outSide0, 32'hC);
        checkOutput("drain occ 1", occ0, 1);
        tick();
        checkOutput("drain done", outValid0, 0);

        // Bubble collapses while the output is stalled
        applyStimulus(1'b1, WA, 32'h1A, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, WB, 32'h1B, 1'b0, 1'b0);
        checkOutput("bubble head moved", outValid0, 1);
        checkOutput("bubble occ 1", occ0, 1);
        checkOutput("bubble in_ready", inReady0, 1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("bubble occ full", occ0, 2);
        checkOutput("bubble in_ready low", inReady0, 0);
        checkOutput("bubble head word", obsWord0, WA);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("bubble second word", obsWord0, WB);
        checkOutput("bubble second side", outSide0, 32'h1B);
        tick();
        checkOutput("bubble drained", occ0, 0);

        // Drop-mode flush with two in flight and a concurrent input
        applyStimulus(1'b1, WA, 32'h2A, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, WB, 32'h2B, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, WC, 32'h2C, 1'b1, 1'b1);
        checkOutput("flush0 pre occ", occ0, 2);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("flush0 out_valid", outValid0, 0);
        checkOutput("flush0 occ", occ0, 0);
        tick();
        checkOutput("flush0 no ghost 1", outValid0, 0);
        tick();
        checkOutput("flush0 no ghost 2", outValid0, 0);
        checkOutput("flush0 occ stays 0", occ0, 0);

        // Squash-mode flush on a word with side effects
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, ws, 32'h66, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, ws, 32'h77, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("squash out_valid", outValid1, 1);
        checkOutput("squash occ", occ1, 2);
        checkOutput("squash word", obsWord1, wsSquashed);
        checkOutput("squash gp_we", gpWe1, 0);
        checkOutput("squash mem_wren", wren1, 0);
        checkOutput("squash mem_rren", rren1, 0);
        checkOutput("squash pc_mux", pc1, 0);
        checkOutput("squash af", af1, 4'hF);
        checkOutput("squash rs", rs1, 5'h11);
        checkOutput("squash rt", rt1, 5'h0C);
        checkOutput("squash rd", rd1, 5'h1B);
        checkOutput("squash side", outSide1, 32'h66);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("squash incoming word", obsWord1, wsSquashed);
        checkOutput("squash incoming side", outSide1, 32'h77);
        tick();
        checkOutput("squash drained", outValid1, 0);

        // Asynchronous reset between edges
        applyStimulus(1'b1, WA, 32'h3A, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, WB, 32'h3B, 1'b0, 1'b0);
        tick();
        checkOutput("areset pre occ", occ0, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("areset out_valid", outValid0, 0);
        checkOutput("areset word", obsWord0, 0);
        checkOutput("areset side", outSide0, 0);
        checkOutput("areset occ", occ0, 0);
        checkOutput("areset in_ready", inReady0, 1);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("areset stays empty", outValid0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
